// File: rtl/hdmi_pixfmt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_pixfmt_pkg
// Description : Shared types, BT.601 coefficients and codes for hdmi_pixfmt.
// Revision    : 1.0 - initial release
// ============================================================================
package hdmi_pixfmt_pkg;

    typedef enum logic [1:0] {
        PIXFMT_RGB444 = 2'd0,
        PIXFMT_YCC444 = 2'd1,
        PIXFMT_YCC422 = 2'd2,
        PIXFMT_RSVD   = 2'd3
    } pixfmt_e;

    // BT.601 studio-range coefficients, scaled by 256
    localparam logic signed [17:0] c_y_r   =  18'sd66;
    localparam logic signed [17:0] c_y_g   =  18'sd129;
    localparam logic signed [17:0] c_y_b   =  18'sd25;
    localparam logic signed [17:0] c_cb_r  = -18'sd38;
    localparam logic signed [17:0] c_cb_g  = -18'sd74;
    localparam logic signed [17:0] c_cb_b  =  18'sd112;
    localparam logic signed [17:0] c_cr_r  =  18'sd112;
    localparam logic signed [17:0] c_cr_g  = -18'sd94;
    localparam logic signed [17:0] c_cr_b  = -18'sd18;
    localparam logic signed [17:0] c_round =  18'sd128;
    localparam logic signed [17:0] c_y_off =  18'sd16;
    localparam logic signed [17:0] c_c_off =  18'sd128;

    localparam logic [23:0] c_blank_rgb444 = 24'h000000;
    localparam logic [23:0] c_blank_ycc444 = 24'h801080;
    localparam logic [23:0] c_blank_ycc422 = 24'h008010;

    typedef struct packed {
        logic        vld;
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [23:0] rgb;
        pixfmt_e     mode;
    } pix_side_t;

    typedef struct packed {
        pix_side_t   side;
        logic        pix_x0;
        logic [7:0]  y;
        logic [7:0]  cb;
        logic [7:0]  cr;
        logic [7:0]  cr_hold;
    } pix_pipe_t;

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [23:0] data;
        pixfmt_e     mode;
    } pix_out_t;

    localparam pix_side_t c_side_rst = '0;
    localparam pix_pipe_t c_pipe_rst = '0;
    localparam pix_out_t  c_out_rst  = '0;

    function automatic pix_side_t side_reset(input pixfmt_e m);
        pix_side_t s;
        s      = c_side_rst;
        s.mode = m;
        return s;
    endfunction

    function automatic pix_pipe_t pipe_reset(input pixfmt_e m);
        pix_pipe_t p;
        p           = c_pipe_rst;
        p.side.mode = m;
        return p;
    endfunction

    function automatic pix_out_t out_reset(input pixfmt_e m);
        pix_out_t o;
        o      = c_out_rst;
        o.mode = m;
        return o;
    endfunction

    function automatic logic [7:0] clamp_u8(input logic signed [17:0] v);
        if (v < 18'sd0) begin
            return 8'd0;
        end else if (v > 18'sd255) begin
            return 8'hFF;
        end else begin
            return v[7:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_pixfmt_rgb2ycbcr.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_rgb2ycbcr
// Description : Two-stage BT.601 RGB888 to YCbCr conversion with clamping.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_rgb2ycbcr
    import hdmi_pixfmt_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [23:0] i_rgb,
    output logic [7:0]  o_y,
    output logic [7:0]  o_cb,
    output logic [7:0]  o_cr
);

    logic signed [17:0] w_r;
    logic signed [17:0] w_g;
    logic signed [17:0] w_b;
    logic signed [17:0] w_y_sum;
    logic signed [17:0] w_cb_sum;
    logic signed [17:0] w_cr_sum;
    logic signed [17:0] r_y_sum;
    logic signed [17:0] r_cb_sum;
    logic signed [17:0] r_cr_sum;
    logic signed [17:0] w_y_scl;
    logic signed [17:0] w_cb_scl;
    logic signed [17:0] w_cr_scl;
    logic [7:0]         r_y;
    logic [7:0]         r_cb;
    logic [7:0]         r_cr;

    assign w_r = $signed({10'd0, i_rgb[23:16]});
    assign w_g = $signed({10'd0, i_rgb[15:8]});
    assign w_b = $signed({10'd0, i_rgb[7:0]});

    assign w_y_sum  = c_y_r  * w_r + c_y_g  * w_g + c_y_b  * w_b + c_round;
    assign w_cb_sum = c_cb_r * w_r + c_cb_g * w_g + c_cb_b * w_b + c_round;
    assign w_cr_sum = c_cr_r * w_r + c_cr_g * w_g + c_cr_b * w_b + c_round;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_y_sum  <= '0;
            r_cb_sum <= '0;
            r_cr_sum <= '0;
        end else begin
            r_y_sum  <= w_y_sum;
            r_cb_sum <= w_cb_sum;
            r_cr_sum <= w_cr_sum;
        end
    end

    // Arithmetic shift floors negative chroma sums before the offset
    assign w_y_scl  = (r_y_sum  >>> 8) + c_y_off;
    assign w_cb_scl = (r_cb_sum >>> 8) + c_c_off;
    assign w_cr_scl = (r_cr_sum >>> 8) + c_c_off;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_y  <= '0;
            r_cb <= '0;
            r_cr <= '0;
        end else begin
            r_y  <= clamp_u8(w_y_scl);
            r_cb <= clamp_u8(w_cb_scl);
            r_cr <= clamp_u8(w_cr_scl);
        end
    end

    assign o_y  = r_y;
    assign o_cb = r_cb;
    assign o_cr = r_cr;

endmodule
`default_nettype wire

// File: rtl/hdmi_pixfmt.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_pixfmt
// Description : HDMI pixel formatter: RGB444 / YCbCr444 / YCbCr422 output.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_pixfmt
    import hdmi_pixfmt_pkg::*;
#(
    parameter int DEFAULT_MODE = 2,
    parameter int EXTRA_DLY    = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_mode,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_de,
    input  logic [23:0] i_rgb,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [23:0] o_data,
    output logic [1:0]  o_mode
);

    localparam pixfmt_e c_default_mode =
        (DEFAULT_MODE == 3) ? PIXFMT_YCC422 : pixfmt_e'(2'(DEFAULT_MODE));

    logic      r_vs_prev;
    pixfmt_e   r_mode;
    logic      w_vs_rise;
    pixfmt_e   w_mode_req;

    pix_side_t r_s1;
    pix_side_t r_s2;
    pix_pipe_t r_s3;

    logic [7:0] w_y;
    logic [7:0] w_cb;
    logic [7:0] w_cr;
    logic [8:0] w_cb_sum;
    logic [8:0] w_cr_sum;
    logic [7:0] w_cb_avg;
    logic [7:0] w_cr_avg;

    pix_out_t  w_out;
    pix_out_t  r_out [0:EXTRA_DLY];

    assign w_vs_rise  = i_vsync & ~r_vs_prev;
    assign w_mode_req = (i_mode == 2'd3) ? PIXFMT_YCC422 : pixfmt_e'(i_mode);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vs_prev <= 1'b0;
            r_mode    <= c_default_mode;
        end else begin
            r_vs_prev <= i_vsync;
            if (w_vs_rise) begin
                r_mode <= w_mode_req;
            end
        end
    end

    // Sideband travels with the pixel; the latch-cycle pixel keeps the old mode
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= side_reset(c_default_mode);
            r_s2 <= side_reset(c_default_mode);
        end else begin
            r_s1.vld   <= 1'b1;
            r_s1.hsync <= i_hsync;
            r_s1.vsync <= i_vsync;
            r_s1.de    <= i_de;
            r_s1.rgb   <= i_rgb;
            r_s1.mode  <= r_mode;
            r_s2       <= r_s1;
        end
    end

    hdmi_rgb2ycbcr u_conv (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_rgb (i_rgb),
        .o_y   (w_y),
        .o_cb  (w_cb),
        .o_cr  (w_cr)
    );

    // Stage 3 holds pixel n while stage 2 / converter present pixel n+1
    assign w_cb_sum = {1'b0, r_s3.cb} + {1'b0, w_cb} + 9'd1;
    assign w_cr_sum = {1'b0, r_s3.cr} + {1'b0, w_cr} + 9'd1;
    assign w_cb_avg = w_cb_sum[8:1];
    assign w_cr_avg = w_cr_sum[8:1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s3 <= pipe_reset(c_default_mode);
        end else begin
            r_s3.side   <= r_s2;
            r_s3.pix_x0 <= r_s2.de & r_s3.side.de & ~r_s3.pix_x0;
            r_s3.y      <= w_y;
            r_s3.cb     <= w_cb;
            r_s3.cr     <= w_cr;
            if (~r_s3.pix_x0) begin
                r_s3.cr_hold <= w_cr_avg;
            end
        end
    end

    always_comb begin
        w_out       = out_reset(r_s3.side.mode);
        w_out.hsync = r_s3.side.hsync;
        w_out.vsync = r_s3.side.vsync;
        w_out.de    = r_s3.side.de;
        if (!r_s3.side.vld) begin
            w_out.data = 24'h000000;
        end else if (!r_s3.side.de) begin
            case (r_s3.side.mode)
                PIXFMT_RGB444: w_out.data = c_blank_rgb444;
                PIXFMT_YCC444: w_out.data = c_blank_ycc444;
                default:       w_out.data = c_blank_ycc422;
            endcase
        end else begin
            case (r_s3.side.mode)
                PIXFMT_RGB444: w_out.data = r_s3.side.rgb;
                PIXFMT_YCC444: w_out.data = {r_s3.cr, r_s3.y, r_s3.cb};
                default: begin
                    if (r_s3.pix_x0) begin
                        w_out.data = {8'h00, r_s3.cr_hold, r_s3.y};
                    end else if (r_s2.de) begin
                        w_out.data = {8'h00, w_cb_avg, r_s3.y};
                    end else begin
                        // Unpaired last pixel of a line keeps its own chroma
                        w_out.data = {8'h00, r_s3.cb, r_s3.y};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i <= EXTRA_DLY; i++) begin
                r_out[i] <= out_reset(c_default_mode);
            end
        end else begin
            r_out[0] <= w_out;
            for (int i = 1; i <= EXTRA_DLY; i++) begin
                r_out[i] <= r_out[i-1];
            end
        end
    end

    assign o_hsync = r_out[EXTRA_DLY].hsync;
    assign o_vsync = r_out[EXTRA_DLY].vsync;
    assign o_de    = r_out[EXTRA_DLY].de;
    assign o_data  = r_out[EXTRA_DLY].data;
    assign o_mode  = r_out[EXTRA_DLY].mode;

endmodule
`default_nettype wire
